run_ctrl: RTL and testbench
===========================

# run_ctrl

Run sequencer for the 9-bit-instruction CPU core. It accepts a four-phase `req`/`done` handshake from the test harness and holds the core in reset for a guaranteed minimum time. It then enables execution, counts run cycles until the core signals program end, and reports completion. It sits between the harness and the core's `reset`/enable inputs, and replaces the raw program-counter compare as the source of `done`.

## Interface
- `RST_CYC`, default 2: cycles `cpu_rst` is held high after a request is accepted; legal range 1..15.
- `CW`, default 16: width of the run-cycle counter.
- `TMO`, default 4000: watchdog limit in run cycles; only used when `RUN_TIMEOUT_EN` is defined; must be less than 2^CW.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  start request from the harness; level-sensitive.
- `cpu_halt`  in  1  core has reached program end (PC at final address); level.
- `cpu_rst`  out  1  synchronous reset to the core, including PC and register file.
- `cpu_en`  out  1  core clock-enable / run permission.
- `done`  out  1  run complete; handshake acknowledge.
- `busy`  out  1  high in RESET and RUN.
- `cycles`  out  CW  run-cycle count of the current or last run.
- `timeout`  out  1  last run was ended by the watchdog.

## Operation
- All outputs are registered. Reset values: state IDLE, `cpu_rst`=1, `cpu_en`=0, `done`=0, `busy`=0, `cycles`=0, `timeout`=0.
- FSM states: IDLE, RESET, RUN, DONE.
- IDLE:
  - `cpu_rst`=1, `cpu_en`=0.
  - If `req`=1, go to RESET, load the reset counter with `RST_CYC`-1, clear `cycles`, and clear `timeout`.
- RESET:
  - `cpu_rst`=1, `busy`=1.
  - The counter decrements each cycle; at 0, go to RUN.
  - `cpu_halt` is ignored.
- RUN:
  - `cpu_rst`=0, `cpu_en`=1, `busy`=1.
  - Each cycle with `cpu_halt`=0, `cycles` increments, saturating at 2^CW-1 with no wrap.
  - When `cpu_halt`=1, go to DONE. `cycles` does not increment on that cycle.
  - `req` dropping during RUN is ignored; the run completes.
- DONE:
  - `cpu_en`=0, `cpu_rst`=0 (core state stays observable), `done`=1.
  - `cycles` and `timeout` are frozen.
  - When `req`=0, go to IDLE. If `req` is already low on entry, `done` is high for exactly one cycle.
- `req` held high through DONE does not restart a run. A new run requires `req` to fall and then rise again, or to be high in IDLE.
- Asynchronous reset asserted in any state forces the reset values immediately. There is no partial completion and `done` is not asserted.

## Timing
- Cycle k: IDLE with `req`=1 sampled. Cycles k+1..k+RST_CYC: RESET (`cpu_rst`=1). Cycle k+RST_CYC+1: first RUN cycle (`cpu_en`=1).
- If `cpu_halt` is first high in RUN cycle m, `done` is high from cycle m+1 and `cpu_en` is low from m+1.
- `done` falls one cycle after `req`=0 is sampled in DONE.
- Minimum request-to-`done` latency: RST_CYC+2 cycles, reached when halt occurs in the first RUN cycle.

## Configuration
- `RUN_TIMEOUT_EN` defined:
  - In RUN, when `cycles` equals `TMO`-1 and `cpu_halt`=0, go to DONE with `timeout`=1 and `cycles`=TMO.
  - If `cpu_halt` and the limit occur in the same cycle, halt wins and `timeout`=0.
- `RUN_TIMEOUT_EN` not defined:
  - `timeout` is tied to 0 and no watchdog logic is built.
  - RUN waits indefinitely for `cpu_halt`.

## Test plan
- Reset, then `req`=1 with RST_CYC=2 and `cpu_halt` rising 10 cycles into RUN -> `cpu_rst` high for 2 cycles after accept, `cpu_en` high for 11 cycles, `done`=1, `cycles`=10.
- `req` held high through DONE, then dropped -> no restart while high; `done` falls 1 cycle after `req`=0; IDLE resumes with `cpu_rst`=1.
- `cpu_halt`=1 throughout RESET and in the first RUN cycle -> RESET lasts its full RST_CYC cycles; `done` rises at the earliest cycle (RST_CYC+2 after accept); `cycles`=0.
- `req` pulsed for 1 cycle, halt after 5 run cycles -> run completes; `done` high for exactly 1 cycle; `cycles`=5.
- `RUN_TIMEOUT_EN`, TMO=20, `cpu_halt` never asserted -> `done`=1, `timeout`=1, `cycles`=20. Repeat with halt in the same cycle as the limit -> `timeout`=0, `cycles`=19.
- Async `reset` asserted mid-RUN at `cycles`=7 -> same cycle: `cpu_en`=0, `cpu_rst`=1, `cycles`=0, `busy`=0; after release with `req`=1, a normal run restarts.

Source files
------------

// File: rtl/run_ctrl.sv
// run_ctrl -- run sequencer for the 9-bit-instruction CPU core.
//
// Accepts a four-phase req/done handshake from the test harness, holds the
// core in reset for RST_CYC cycles, lets it run until cpu_halt, counts the
// run cycles, and acknowledges with done until req is released.
//
// Optional feature: define RUN_TIMEOUT_EN to build a run-cycle watchdog
// that ends a run after TMO cycles and flags it on `timeout`. Without the
// macro, `timeout` is tied low and RUN waits indefinitely for cpu_halt.
//
// Parameters:
//   RST_CYC  cycles cpu_rst is held after a request is accepted (1..15)
//   CW       width of the run-cycle counter
//   TMO      watchdog limit in run cycles (< 2^CW, RUN_TIMEOUT_EN only)
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous reset, active low
//   req       in   start request (level)
//   cpu_halt  in   core reached program end (level)
//   cpu_rst   out  synchronous reset to the core
//   cpu_en    out  core clock-enable / run permission
//   done      out  run complete / handshake acknowledge
//   busy      out  high in RESET and RUN
//   cycles    out  run-cycle count of the current or last run
//   timeout   out  last run was ended by the watchdog
module run_ctrl #(
    parameter int RST_CYC = 2,
    parameter int CW      = 16,
    parameter int TMO     = 4000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          cpu_halt,
    output logic          cpu_rst,
    output logic          cpu_en,
    output logic          done,
    output logic          busy,
    output logic [CW-1:0] cycles,
    output logic          timeout
);

    // Elaboration-time sanity check on the configuration.
    if (RST_CYC < 1 || RST_CYC > 15 || TMO < 1 || TMO >= (64'd1 << CW)) begin : g_param_chk
        $error("run_ctrl: parameter out of range");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RESET = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CW-1:0] CYC_MAX   = '1;
    localparam logic [3:0]    RST_LOAD  = 4'(RST_CYC - 1);

    logic [1:0]    state, state_nx;
    logic [3:0]    rcnt, rcnt_nx;
    logic [CW-1:0] cycles_nx;
    logic          accept;
    logic          tmo_hit;

    assign accept = (state == S_IDLE) && req;

`ifdef RUN_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

    // Halt has priority over the watchdog when both land in the same cycle.
    assign tmo_hit = (state == S_RUN) && !cpu_halt && (cycles == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            timeout <= 1'b0;
        else if (accept)
            timeout <= 1'b0;
        else if (tmo_hit)
            timeout <= 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        rcnt_nx   = rcnt;
        cycles_nx = cycles;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nx  = S_RESET;
                    rcnt_nx   = RST_LOAD;
                    cycles_nx = '0;
                end
            end
            S_RESET: begin
                // cpu_halt is deliberately ignored while the core is in reset.
                if (rcnt == 4'd0)
                    state_nx = S_RUN;
                else
                    rcnt_nx = rcnt - 4'd1;
            end
            S_RUN: begin
                if (cpu_halt) begin
                    state_nx = S_DONE;
                end else begin
                    // Saturate rather than wrap; on a watchdog hit this
                    // increment lands the count exactly on TMO.
                    if (cycles != CYC_MAX)
                        cycles_nx = cycles + 1'b1;
                    if (tmo_hit)
                        state_nx = S_DONE;
                end
            end
            S_DONE: begin
                // Stay here while req is held so a level-high req cannot
                // retrigger; the harness must drop it first.
                if (!req)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            rcnt    <= 4'd0;
            cycles  <= '0;
            cpu_rst <= 1'b1;
            cpu_en  <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            rcnt    <= rcnt_nx;
            cycles  <= cycles_nx;
            cpu_rst <= (state_nx == S_IDLE) || (state_nx == S_RESET);
            cpu_en  <= (state_nx == S_RUN);
            done    <= (state_nx == S_DONE);
            busy    <= (state_nx == S_RESET) || (state_nx == S_RUN);
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl. Each run is described by its halt point
// and req schedule; the expected output waveform is derived from the
// handshake timing rules with plain cycle arithmetic.
module tb_run_ctrl;

    localparam int RST  = 2;
    localparam int CW   = 6;
    localparam int CMAX = 63;
`ifdef RUN_TIMEOUT_EN
    localparam int TMO    = 20;
    localparam bit TMO_ON = 1'b1;
`else
    localparam int TMO    = 40;
    localparam bit TMO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req = 1'b0;
    logic          cpu_halt = 1'b0;
    logic          cpu_rst, cpu_en, done, busy, timeout;
    logic [CW-1:0] cycles;

    int n_cmp = 0;
    int n_err = 0;
    int last_cyc = 0;
    bit last_tmo = 1'b0;

    run_ctrl #(.RST_CYC(RST), .CW(CW), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .cpu_halt(cpu_halt),
        .cpu_rst(cpu_rst), .cpu_en(cpu_en), .done(done), .busy(busy),
        .cycles(cycles), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // One run, starting at a negedge with the DUT idle. c counts posedges
    // since req was raised: c=1..RST is RESET, RUN starts at c=RST+1.
    // h: RUN cycle in which halt is first high (-1: never).
    // rdrop: first c at which req is driven low.
    // rst_halt: halt during RESET (0, 1, 2=random). req_noise: toggle req
    // randomly during RESET/RUN after rdrop.
    task automatic run_one(input string name, input int h_in, input int rdrop,
                           input int rst_halt, input bit req_noise);
        bit req_at[256];
        bit halt_at[256];
        int h, run0, done_c, idle_c, exp_cyc;
        bit exp_tmo;
        logic [CW+4:0] got, exp;
        h = h_in;
        if (h < 0 && !TMO_ON) h = 0;
        run0 = RST + 1;
        if (TMO_ON && (h < 0 || h > TMO - 1)) begin
            done_c = run0 + TMO; exp_cyc = TMO; exp_tmo = 1'b1;
        end else begin
            done_c = run0 + h + 1; exp_cyc = (h > CMAX) ? CMAX : h; exp_tmo = 1'b0;
        end
        idle_c = ((done_c > rdrop) ? done_c : rdrop) + 1;
        for (int c = 0; c < 256; c++) begin
            req_at[c] = (c < rdrop);
            if (req_noise && c >= 1 && c < done_c && c >= rdrop)
                req_at[c] = 1'($urandom_range(0, 1));
            if (c <= RST)
                halt_at[c] = (rst_halt == 2) ? 1'($urandom_range(0, 1)) : (rst_halt == 1);
            else if (c < done_c - 1)
                halt_at[c] = 1'b0;
            else if (c == done_c - 1)
                halt_at[c] = !exp_tmo;
            else
                halt_at[c] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c <= idle_c + 1 && c < 255; c++) begin
            bit e_rst, e_en, e_done, e_busy, e_tmo;
            int e_cyc;
            e_rst = 1'b1; e_en = 1'b0; e_done = 1'b0; e_busy = 1'b0;
            e_tmo = exp_tmo; e_cyc = exp_cyc;
            if (c == 0) begin
                e_tmo = last_tmo; e_cyc = last_cyc;
            end else if (c <= RST) begin
                e_busy = 1'b1; e_tmo = 1'b0; e_cyc = 0;
            end else if (c < done_c) begin
                e_rst = 1'b0; e_en = 1'b1; e_busy = 1'b1; e_tmo = 1'b0;
                e_cyc = (c - run0 > CMAX) ? CMAX : c - run0;
            end else if (c < idle_c) begin
                e_rst = 1'b0; e_done = 1'b1;
            end
            exp = {e_rst, e_en, e_done, e_busy, e_tmo, CW'(e_cyc)};
            got = {cpu_rst, cpu_en, done, busy, timeout, cycles};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s c=%0d: rst/en/done/busy/tmo=%b%b%b%b%b cycles=%0d, expected %b%b%b%b%b cycles=%0d",
                         name, c, cpu_rst, cpu_en, done, busy, timeout, cycles,
                         e_rst, e_en, e_done, e_busy, e_tmo, e_cyc);
            end
            req = req_at[c];
            cpu_halt = halt_at[c];
            @(negedge clk);
        end
        req = 1'b0;
        cpu_halt = 1'b0;
        last_cyc = exp_cyc;
        last_tmo = exp_tmo;
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 1'b0; cpu_halt = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cpu_rst, cpu_en, done, busy, timeout, cycles} !== {5'b10000, CW'(0)}) begin
            n_err++;
            $display("FAIL reset_state: rst/en/done/busy/tmo=%b%b%b%b%b cycles=%0d, expected 10000 cycles=0",
                     cpu_rst, cpu_en, done, busy, timeout, cycles);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cpu_rst, cpu_en, done, busy} !== 4'b1000) begin
            n_err++;
            $display("FAIL idle_after_reset: rst/en/done/busy=%b%b%b%b, expected 1000",
                     cpu_rst, cpu_en, done, busy);
        end
        last_cyc = 0; last_tmo = 1'b0;
    endtask

    task automatic test_basic();
        run_one("basic_halt10", 10, RST + 2 + 10 + 3, 0, 1'b0);
    endtask

    task automatic test_hold_through_done();
        run_one("hold_done", 3, RST + 2 + 3 + 6, 0, 1'b0);
    endtask

    task automatic test_early_halt();
        run_one("early_halt", 0, RST + 2, 1, 1'b0);
    endtask

    task automatic test_pulse();
        run_one("req_pulse", 5, 1, 0, 1'b0);
    endtask

    task automatic test_limit();
`ifdef RUN_TIMEOUT_EN
        run_one("watchdog", -1, 2, 0, 1'b0);
        run_one("halt_at_limit", TMO - 1, 2, 0, 1'b0);
`else
        run_one("saturate", 70, 2, 0, 1'b0);
`endif
    endtask

    task automatic test_async_reset();
        req = 1'b1; cpu_halt = 1'b0;
        for (int c = 0; c < RST + 1 + 7; c++) @(negedge clk);
        n_cmp++;
        if ({cpu_en, cycles} !== {1'b1, CW'(7)}) begin
            n_err++;
            $display("FAIL pre_async_run: en=%b cycles=%0d, expected en=1 cycles=7", cpu_en, cycles);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({cpu_rst, cpu_en, done, busy, timeout, cycles} !== {5'b10000, CW'(0)}) begin
            n_err++;
            $display("FAIL async_reset: rst/en/done/busy/tmo=%b%b%b%b%b cycles=%0d, expected 10000 cycles=0",
                     cpu_rst, cpu_en, done, busy, timeout, cycles);
        end
        @(negedge clk);
        reset = 1'b1;
        last_cyc = 0; last_tmo = 1'b0;
        run_one("restart", 4, RST + 2 + 4 + 1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            int h, rd;
            h  = int'($urandom_range(0, 40));
            rd = int'($urandom_range(1, RST + 2 + h + 5));
            run_one("random", h, rd, 2, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_through_done();
        test_early_halt();
        test_pulse();
        test_limit();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
